// File: rtl/pc_unit.sv
// pc_unit: registered program counter for the bc6502 core family.
// Handles increment, relative branch, block-move rewind, absolute jump and
// call/return through a small circular return-address stack. Optional bank
// wrap keeps arithmetic results inside the current bank.
module pc_unit #(
    parameter int unsigned     ABW    = 24,
    parameter int unsigned     DW     = 8,
    parameter int unsigned     BANKW  = 16,
    parameter int unsigned     RSD    = 4,
    parameter logic [ABW-1:0]  RST_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [2:0]       op,
    input  logic [DW-1:0]    disp,
    input  logic [ABW-1:0]   addr,
    input  logic             bankwrap,
    output logic [ABW-1:0]   pc,
    output logic [ABW-1:0]   pc_nxt,
    output logic             page_cross,
    output logic             rs_full,
    output logic             rs_empty,
    output logic             rs_err
);

    localparam int unsigned PW = $clog2(RSD);
    localparam int unsigned CW = PW + 1;

    localparam logic [2:0] OpHold  = 3'd0;
    localparam logic [2:0] OpInc   = 3'd1;
    localparam logic [2:0] OpBra   = 3'd2;
    localparam logic [2:0] OpMvrew = 3'd3;
    localparam logic [2:0] OpJmp   = 3'd4;
    localparam logic [2:0] OpJsr   = 3'd5;
    localparam logic [2:0] OpRts   = 3'd6;
    localparam logic [2:0] OpRti   = 3'd7;

    localparam logic [PW-1:0]  PtrOne  = PW'(1);
    localparam logic [CW-1:0]  CntOne  = CW'(1);
    localparam logic [CW-1:0]  CntFull = CW'(RSD);
    localparam logic [ABW-1:0] AddrOne = ABW'(1);
    localparam logic [ABW-1:0] AddrThr = ABW'(3);

    logic [ABW-1:0] pc_q, pc_d;
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           cross_q, cross_d;
    logic           err_q, err_d;
    logic [ABW-1:0] stack_q [RSD];

    logic [ABW-1:0] top;
    logic [ABW-1:0] disp_ext;
    logic [ABW-1:0] base;
    logic [ABW-1:0] sum;
    logic           arith;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;

    assign full     = (cnt_q == CntFull);
    assign empty    = (cnt_q == '0);
    assign top      = stack_q[wptr_q - PtrOne];
    assign disp_ext = {{(ABW-DW){disp[DW-1]}}, disp};

    // Next-state decode for pc, stack pointers and flags.
    always_comb begin
        pc_d    = pc_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        cross_d = cross_q;
        err_d   = err_q;
        base    = pc_q;
        sum     = pc_q;
        arith   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        if (ce) begin
            cross_d = 1'b0;
            case (op)
                OpInc: begin
                    sum   = pc_q + AddrOne;
                    arith = 1'b1;
                end
                OpBra: begin
                    sum   = pc_q + disp_ext;
                    arith = 1'b1;
                end
                OpMvrew: begin
                    sum   = pc_q - AddrThr;
                    arith = 1'b1;
                end
                OpJmp: pc_d = addr;
                OpJsr: begin
                    push = 1'b1;
                    pc_d = addr;
                end
                OpRts: begin
                    if (empty) begin
                        err_d = 1'b1;
                    end else begin
                        pop   = 1'b1;
                        base  = top;
                        sum   = top + AddrOne;
                        arith = 1'b1;
                    end
                end
                OpRti: begin
                    if (empty) begin
                        err_d = 1'b1;
                    end else begin
                        pop  = 1'b1;
                        pc_d = top;
                    end
                end
                default: ;
            endcase
            if (arith) begin
                pc_d = bankwrap ? {base[ABW-1:BANKW], sum[BANKW-1:0]} : sum;
            end
            if (op == OpBra) begin
                cross_d = (pc_d[ABW-1:8] != pc_q[ABW-1:8]);
            end
            // A push onto a full stack overwrites the oldest slot, which is
            // exactly where wptr already points.
            if (push) begin
                wptr_d = wptr_q + PtrOne;
                if (full) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            if (pop) begin
                wptr_d = wptr_q - PtrOne;
                cnt_d  = cnt_q - CntOne;
            end
        end
        if (rst) begin
            pc_d = RST_PC;
        end
    end

    // Architectural state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RST_PC;
            wptr_q  <= '0;
            cnt_q   <= '0;
            cross_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            cross_q <= cross_d;
            err_q   <= err_d;
        end
    end

    // Return-stack RAM; contents need no reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            stack_q[wptr_q] <= pc_q;
        end
    end

    assign pc         = pc_q;
    assign pc_nxt     = pc_d;
    assign page_cross = cross_q;
    assign rs_full    = full;
    assign rs_empty   = empty;
    assign rs_err     = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed scenarios plus randomized ops checked
// against a behavioural model using a queue for the return stack.
module tb_pc_unit;

    localparam int unsigned ABW   = 24;
    localparam int unsigned DW    = 8;
    localparam int unsigned BANKW = 16;
    localparam int unsigned RSD   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            ce;
    logic [2:0]      op;
    logic [DW-1:0]   disp;
    logic [ABW-1:0]  addr;
    logic            bankwrap;
    logic [ABW-1:0]  pc;
    logic [ABW-1:0]  pc_nxt;
    logic            page_cross;
    logic            rs_full;
    logic            rs_empty;
    logic            rs_err;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    logic [ABW-1:0] m_pc;
    logic [ABW-1:0] m_stk [$];
    bit             m_cross;
    bit             m_err;

    pc_unit #(
        .ABW    (ABW),
        .DW     (DW),
        .BANKW  (BANKW),
        .RSD    (RSD),
        .RST_PC (24'h000000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .op         (op),
        .disp       (disp),
        .addr       (addr),
        .bankwrap   (bankwrap),
        .pc         (pc),
        .pc_nxt     (pc_nxt),
        .page_cross (page_cross),
        .rs_full    (rs_full),
        .rs_empty   (rs_empty),
        .rs_err     (rs_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [ABW-1:0] got, input logic [ABW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %06h expected %06h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [ABW-1:0] wrap(input logic [ABW-1:0] b, input logic [ABW-1:0] s,
                                            input bit bw);
        logic [ABW-1:0] mask;
        mask = ABW'((1 << BANKW) - 1);
        return bw ? ((b & ~mask) | (s & mask)) : s;
    endfunction

    // One clock: drive inputs, check pc_nxt, clock, advance the model, check outputs.
    task automatic step(input bit r, input bit c, input logic [2:0] o, input logic [DW-1:0] d,
                        input logic [ABW-1:0] a, input bit bw);
        logic [ABW-1:0] npc;
        logic [ABW-1:0] v;
        bit ncross, nerr, do_push, do_pop;
        rst = r; ce = c; op = o; disp = d; addr = a; bankwrap = bw;
        #1;
        npc = m_pc; ncross = m_cross; nerr = m_err; do_push = 0; do_pop = 0;
        if (c) begin
            ncross = 0;
            case (o)
                3'd1: npc = wrap(m_pc, m_pc + 24'd1, bw);
                3'd2: begin
                    npc = wrap(m_pc, ABW'(int'(m_pc) + int'($signed(d))), bw);
                    ncross = ((npc >> 8) != (m_pc >> 8));
                end
                3'd3: npc = wrap(m_pc, ABW'(int'(m_pc) - 3), bw);
                3'd4: npc = a;
                3'd5: begin npc = a; do_push = 1; end
                3'd6, 3'd7: begin
                    if (m_stk.size() == 0) nerr = 1;
                    else begin
                        v = m_stk[m_stk.size() - 1];
                        do_pop = 1;
                        npc = (o == 3'd6) ? wrap(v, v + 24'd1, bw) : v;
                    end
                end
                default: ;
            endcase
        end
        check("pc_nxt", pc_nxt, r ? 24'h000000 : npc);
        @(posedge clk);
        #1;
        if (r) begin
            m_pc = 0; m_stk.delete(); m_cross = 0; m_err = 0;
        end else begin
            if (do_push) begin
                if (m_stk.size() == RSD) begin
                    void'(m_stk.pop_front());
                    nerr = 1;
                end
                m_stk.push_back(m_pc);
            end
            if (do_pop) void'(m_stk.pop_back());
            m_pc = npc; m_cross = ncross; m_err = nerr;
        end
        check("pc", pc, m_pc);
        check("page_cross", ABW'(page_cross), ABW'(m_cross));
        check("rs_full", ABW'(rs_full), ABW'(m_stk.size() == RSD));
        check("rs_empty", ABW'(rs_empty), ABW'(m_stk.size() == 0));
        check("rs_err", ABW'(rs_err), ABW'(m_err));
    endtask

    initial begin
        m_pc = 0; m_cross = 0; m_err = 0;

        // Reset and increment
        step(1, 1, 3'd1, 8'h00, 24'h0, 0);
        check("rst_pc", pc, 24'h000000);
        check("rst_empty", ABW'(rs_empty), 24'd1);
        repeat (3) step(0, 1, 3'd1, 8'h00, 24'h0, 0);
        check("inc3", pc, 24'h000003);
        step(0, 0, 3'd1, 8'h00, 24'h0, 0);
        check("ce_hold", pc, 24'h000003);
        check("ce_hold_nxt", pc_nxt, 24'h000003);

        // Full-width vs bank wrap
        step(0, 1, 3'd4, 8'h00, 24'h00FFFF, 0);
        step(0, 1, 3'd1, 8'h00, 24'h0, 0);
        check("inc_full", pc, 24'h010000);
        step(0, 1, 3'd4, 8'h00, 24'h12FFFF, 1);
        step(0, 1, 3'd1, 8'h00, 24'h0, 1);
        check("inc_bank", pc, 24'h120000);

        // Branches and page crossing
        step(0, 1, 3'd4, 8'h00, 24'h000105, 0);
        step(0, 1, 3'd2, 8'hF0, 24'h0, 0);
        check("bra_back", pc, 24'h0000F5);
        check("bra_cross", ABW'(page_cross), 24'd1);
        step(0, 1, 3'd1, 8'h00, 24'h0, 0);
        check("cross_clr", ABW'(page_cross), 24'd0);
        step(0, 1, 3'd4, 8'h00, 24'h000110, 0);
        step(0, 1, 3'd2, 8'h05, 24'h0, 0);
        check("bra_fwd", pc, 24'h000115);
        check("bra_nocross", ABW'(page_cross), 24'd0);

        // Block-move rewind
        step(0, 1, 3'd4, 8'h00, 24'h000002, 0);
        step(0, 1, 3'd3, 8'h00, 24'h0, 0);
        check("mvrew_full", pc, 24'hFFFFFF);
        step(0, 1, 3'd4, 8'h00, 24'h340001, 1);
        step(0, 1, 3'd3, 8'h00, 24'h0, 1);
        check("mvrew_bank", pc, 24'h34FFFE);

        // Call and return
        step(0, 1, 3'd4, 8'h00, 24'h000200, 0);
        step(0, 1, 3'd5, 8'h00, 24'h001000, 0);
        step(0, 1, 3'd6, 8'h00, 24'h0, 0);
        check("jsr_rts", pc, 24'h000201);
        check("rts_empty", ABW'(rs_empty), 24'd1);
        step(0, 1, 3'd4, 8'h00, 24'h000300, 0);
        step(0, 1, 3'd5, 8'h00, 24'h001000, 0);
        step(0, 1, 3'd7, 8'h00, 24'h0, 0);
        check("jsr_rti", pc, 24'h000300);
        check("rti_empty", ABW'(rs_empty), 24'd1);

        // Overflow, then drain and underflow
        step(0, 1, 3'd4, 8'h00, 24'h000000, 0);
        for (int i = 1; i <= 5; i++) step(0, 1, 3'd5, 8'h00, ABW'(i * 16), 0);
        check("ovf_full", ABW'(rs_full), 24'd1);
        check("ovf_err", ABW'(rs_err), 24'd1);
        for (int i = 4; i >= 1; i--) begin
            step(0, 1, 3'd6, 8'h00, 24'h0, 0);
            check("drain", pc, ABW'(i * 16 + 1));
        end
        step(0, 1, 3'd6, 8'h00, 24'h0, 0);
        check("unf_hold", pc, 24'h000011);
        step(0, 1, 3'd1, 8'h00, 24'h0, 0);
        check("err_sticky", ABW'(rs_err), 24'd1);
        step(1, 1, 3'd5, 8'h00, 24'h0ABCDE, 0);
        check("err_rst", ABW'(rs_err), 24'd0);
        check("rst_discard", ABW'(rs_empty), 24'd1);

        // Randomized ops against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                 3'($urandom_range(0, 7)), 8'($urandom), 24'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Registered program-counter unit for the bc6502 core family. It holds the PC and applies increment, signed relative branch, block-move rewind, absolute jump, and call/return operations, with an integrated return-address stack. An optional bank-wrap mode confines arithmetic to the low address bits, 65816-style. It replaces the purely combinational PC adder in the fetch path.

## Interface
- ABW, 24: address/PC width in bits.
- DW, 8: branch displacement width; sign-extended to ABW.
- BANKW, 16: bank boundary width; BANKW < ABW.
- RSD, 4: return-stack depth; power of two, ≥ 2.
- RST_PC, 0: PC value after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high; overrides ce.
- ce  in  1  clock enable; when 0, all state holds and op is ignored.
- op  in  3  operation: 0 HOLD, 1 INC, 2 BRA, 3 MVREW, 4 JMP, 5 JSR, 6 RTS, 7 RTI.
- disp  in  DW  signed branch displacement, used by BRA.
- addr  in  ABW  absolute target, used by JMP/JSR.
- bankwrap  in  1  1 = INC/BRA/MVREW/RTS results keep upper ABW-BANKW bits of the base.
- pc  out  ABW  current PC (registered).
- pc_nxt  out  ABW  combinational value pc takes at the next edge.
- page_cross  out  1  registered; last executed BRA changed pc[ABW-1:8].
- rs_full  out  1  stack count == RSD.
- rs_empty  out  1  stack count == 0.
- rs_err  out  1  sticky overflow/underflow flag; cleared only by rst.

## Operation
- HOLD: pc unchanged.
- INC: base = pc; result = pc + 1.
- BRA: base = pc; result = pc + sext(disp).
- MVREW: base = pc; result = pc − 3. Used to re-execute MVN/MVP.
- JMP: pc ← addr. Bankwrap is ignored.
- JSR: push pc (pre-op value), then pc ← addr.
- RTS: pop top; base = popped; result = popped + 1.
- RTI: pop top; pc ← popped exactly. Bankwrap is ignored.

Arithmetic is modulo 2^ABW. With bankwrap=1, result = {base[ABW-1:BANKW], sum[BANKW-1:0]}.

Return stack:
- Circular buffer of RSD entries, with a write pointer and a count of 0..RSD.
- JSR when full: the oldest entry is overwritten, count stays RSD, rs_err ← 1.
- RTS/RTI when empty: pc holds, count stays 0, rs_err ← 1.
- Top entry is read combinationally at index wptr−1.

page_cross:
- On BRA it is set to (new pc[ABW-1:8] ≠ old pc[ABW-1:8]).
- Any other op with ce=1 clears it.
- It holds when ce=0.

pc_nxt:
- Mirrors the update logic exactly.
- Equals pc when ce=0, op=HOLD, or on underflowing RTS/RTI.
- Equals RST_PC when rst=1.

Reset values: pc=RST_PC, count=0, wptr=0, page_cross=0, rs_err=0, rs_empty=1, rs_full=0. Stack RAM contents are don't-care.

Reset mid-operation: rst asserted in the same cycle as any op discards that op entirely, including any stack push or pop.

## Timing
- Latency is 1 cycle: op presented in cycle N produces the updated pc after edge N.
- pc_nxt is valid in the same cycle.
- Ops issue back-to-back every enabled cycle with no stall and no handshake.
- JSR then RTS in the next cycle returns the pushed pc + 1.
- rs_full/rs_empty are registered-state derived and reflect count after the edge.
- rs_err asserts on the edge that performs the faulting op.
- Stack entries are written on the edge; no write-then-read bypass is needed within one cycle, since only one op issues per cycle.

## Test plan
- Reset and INC: rst=1 for one edge → pc=0, rs_empty=1. Then 3× INC → pc=3. ce=0 with op=INC → pc stays 3 and pc_nxt=3.
- Full-width wrap vs bank wrap:
  - pc=0x00FFFF, bankwrap=0, INC → 0x010000.
  - pc=0x12FFFF, bankwrap=1, INC → 0x120000.
- Branch and page crossing:
  - pc=0x000105, disp=0xF0 (−16), BRA → pc=0x0000F5, page_cross=1.
  - Next INC → page_cross=0.
  - disp=0x05 from 0x000110 → 0x000115, page_cross=0.
- MVREW: pc=0x000002, bankwrap=0 → 0xFFFFFF. pc=0x340001, bankwrap=1 → 0x34FFFE.
- Call/return:
  - JSR addr=0x001000 at pc=0x000200, then RTS → pc=0x000201.
  - JSR at pc=0x000300, then RTI → pc=0x000300.
  - rs_empty returns to 1 after each.
- Stack faults:
  - 5× JSR (RSD=4) → rs_full=1, rs_err=1, and 4 RTS return the last 4 pushed values +1.
  - A 5th RTS leaves pc unchanged.
  - rs_err stays 1 until rst.
